// File: rtl/add.sv
// 32-bit carry-lookahead adder with CF/OF flags and a registered side-channel.
// Define ADD_STICKY_OVF_EN to build the sticky overflow register and its OF_sticky port.
module add (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sr,
    input  logic [31:0] tg,
    input  logic        cin,
    input  logic        ovf_clr,
    output logic [31:0] res,
    output logic        CF,
    output logic        OF,
    output logic [31:0] res_q,
    output logic        CF_q,
    output logic        OF_q
`ifdef ADD_STICKY_OVF_EN
    ,
    output logic        OF_sticky
`endif
);

    logic [31:0] g, p, c;
    logic [7:0]  grp_g, grp_p;
    logic [8:0]  c_grp;
    logic        acc, pp;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        g     = sr & tg;
        p     = sr ^ tg;
        grp_g = '0;
        grp_p = '0;
        c_grp = '0;
        c     = '0;
        acc   = 1'b0;
        pp    = 1'b0;

        for (int k = 0; k < 8; k++) begin
            grp_p[k] = &p[4*k +: 4];
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end

        // Second level: each group carry is a flat sum of products over lower groups and cin.
        c_grp[0] = cin;
        for (int k = 0; k < 8; k++) begin
            acc = grp_g[k];
            pp  = grp_p[k];
            for (int j = k - 1; j >= 0; j--) begin
                acc = acc | (pp & grp_g[j]);
                pp  = pp & grp_p[j];
            end
            c_grp[k+1] = acc | (pp & cin);
        end

        for (int k = 0; k < 8; k++) begin
            c[4*k]   = c_grp[k];
            c[4*k+1] = g[4*k] | (p[4*k] & c_grp[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c_grp[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c_grp[k]);
        end
    end

    assign res = p ^ c;
    assign CF  = c_grp[8];
    assign OF  = (sr[31] == tg[31]) && (res[31] != sr[31]);

    logic [31:0] res_d;
    logic        CF_d, OF_d;

    always_comb begin
        res_d = res;
        CF_d  = CF;
        OF_d  = OF;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            CF_q  <= 1'b0;
            OF_q  <= 1'b0;
        end else begin
            res_q <= res_d;
            CF_q  <= CF_d;
            OF_q  <= OF_d;
        end
    end

`ifdef ADD_STICKY_OVF_EN
    logic OF_sticky_d;

    always_comb begin
        OF_sticky_d = OF_sticky;
        if (ovf_clr) begin
            OF_sticky_d = 1'b0;
        end else if (OF) begin
            OF_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            OF_sticky <= 1'b0;
        end else begin
            OF_sticky <= OF_sticky_d;
        end
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
`endif

endmodule

// File: tb/tb_add.sv
// Self-checking bench for add: directed literal vectors plus randomized regression
// against a 33-bit arithmetic model, checked on every falling edge.
module tb_add;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] sr = '0, tg = '0;
    logic        cin = 1'b0, ovf_clr = 1'b0;
    logic [31:0] res, res_q;
    logic        CF, OF, CF_q, OF_q;
`ifdef ADD_STICKY_OVF_EN
    logic        OF_sticky;
`endif

    add dut (
        .clk      (clk),
        .rst      (rst),
        .sr       (sr),
        .tg       (tg),
        .cin      (cin),
        .ovf_clr  (ovf_clr),
        .res      (res),
        .CF       (CF),
        .OF       (OF),
        .res_q    (res_q),
        .CF_q     (CF_q),
        .OF_q     (OF_q)
`ifdef ADD_STICKY_OVF_EN
        ,
        .OF_sticky(OF_sticky)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {OF, CF, res} straight from the arithmetic definition.
    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic ci);
        logic [32:0] s;
        logic        of;
        s  = {1'b0, a} + {1'b0, b} + {32'b0, ci};
        of = (a[31] == b[31]) && (s[31] != a[31]);
        return {of, s};
    endfunction

    // Expected registered outputs, advanced at each rising edge from the pre-edge inputs.
    logic [31:0] exp_res_q = '0;
    logic        exp_cf_q = 1'b0, exp_of_q = 1'b0, exp_sticky = 1'b0;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        logic [33:0] m;
        m = ref_add(sr, tg, cin);
        if (rst) begin
            exp_res_q  = '0;
            exp_cf_q   = 1'b0;
            exp_of_q   = 1'b0;
            exp_sticky = 1'b0;
            armed      = 1'b1;
        end else begin
            exp_res_q = m[31:0];
            exp_cf_q  = m[32];
            exp_of_q  = m[33];
            if (ovf_clr)    exp_sticky = 1'b0;
            else if (m[33]) exp_sticky = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [33:0] m;
        if (armed) begin
            m = ref_add(sr, tg, cin);
            check("res",   res,   m[31:0]);
            check("CF",    {31'b0, CF},   {31'b0, m[32]});
            check("OF",    {31'b0, OF},   {31'b0, m[33]});
            check("res_q", res_q, exp_res_q);
            check("CF_q",  {31'b0, CF_q}, {31'b0, exp_cf_q});
            check("OF_q",  {31'b0, OF_q}, {31'b0, exp_of_q});
`ifdef ADD_STICKY_OVF_EN
            check("OF_sticky", {31'b0, OF_sticky}, {31'b0, exp_sticky});
`endif
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic clr, input logic r);
        @(posedge clk);
        #1;
        sr = a; tg = b; cin = ci; ovf_clr = clr; rst = r;
        #1;
    endtask

    task automatic check_comb(input string name, input logic [31:0] e_res,
                              input logic e_cf, input logic e_of);
        check({name, ".res"}, res, e_res);
        check({name, ".CF"},  {31'b0, CF}, {31'b0, e_cf});
        check({name, ".OF"},  {31'b0, OF}, {31'b0, e_of});
    endtask

    initial begin
        drive(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        check_comb("1+1 in reset", 32'h0000_0002, 1'b0, 1'b0);

        drive(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        check("reset res_q", res_q, 32'h0);
        check("reset CF_q",  {31'b0, CF_q}, 32'h0);
        check("reset OF_q",  {31'b0, OF_q}, 32'h0);
`ifdef ADD_STICKY_OVF_EN
        check("reset sticky", {31'b0, OF_sticky}, 32'h0);
`endif
        check_comb("ffff+1", 32'h0001_0000, 1'b0, 1'b0);

        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        check("res_q ffff+1", res_q, 32'h0001_0000);
        check_comb("wrap", 32'h0000_0000, 1'b1, 1'b0);

        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        check("CF_q wrap", {31'b0, CF_q}, 32'h1);
        check_comb("pos ovf", 32'h8000_0000, 1'b0, 1'b1);

        drive(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        check("OF_q pos ovf", {31'b0, OF_q}, 32'h1);
`ifdef ADD_STICKY_OVF_EN
        check("sticky set", {31'b0, OF_sticky}, 32'h1);
`endif

        drive(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        check("OF_q clear", {31'b0, OF_q}, 32'h0);
`ifdef ADD_STICKY_OVF_EN
        check("sticky hold", {31'b0, OF_sticky}, 32'h1);
`endif
        check_comb("neg ovf", 32'h0000_0000, 1'b1, 1'b1);

        drive(32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b0);
        check_comb("1+1+cin", 32'h0000_0003, 1'b0, 1'b0);

        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
        check_comb("clr+ovf", 32'h8000_0000, 1'b0, 1'b1);

        drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        check("OF_q clr+ovf", {31'b0, OF_q}, 32'h1);
`ifdef ADD_STICKY_OVF_EN
        check("clear wins", {31'b0, OF_sticky}, 32'h0);
`endif
        check_comb("cin chain", 32'h0000_0000, 1'b1, 1'b0);

        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        check_comb("comb in reset", 32'h8000_0000, 1'b0, 1'b1);
        drive(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0);
        check("midreset res_q", res_q, 32'h0);
        check("midreset OF_q", {31'b0, OF_q}, 32'h0);

        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: a = {a[31], {31{~a[31]}}};
                1: b = ~a;
                default: ;
            endcase
            drive(a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 63) == 0));
        end

        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
